apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 148 ++++++++++++++
 tb/tb_apb_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// Purpose : converts a valid/ready command into one APB transfer and returns a valid/ready response.
// Latency : accept cycle N -> SETUP N+1 -> ACCESS N+2 (+ wait states) -> rsp_valid N+3 at best; one command per 4 cycles.
// Backpr. : cmd_ready only in IDLE (one transfer in flight); RESP holds until rsp_ready, ACCESS holds until PREADY.
//
// Ports   : PCLK/PRESETn (sync, active-low) clock and reset;
//           cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata command side;
//           rsp_valid/rsp_ready/rsp_rdata/rsp_err response side;
//           PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA/PREADY/PSLVERR APB completer side.
// Option  : define APB_MASTER_TIMEOUT_EN to add an ACCESS-phase watchdog that aborts
//           after TIMEOUT cycles without PREADY (response flagged with rsp_err).
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("apb_master: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic                    pwrite_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    accept;
    logic                    done;
    logic                    wd_fire;
    logic                    wd_expired;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wd_cnt;

    // Counts ACCESS cycles without PREADY; the cycle that sees WD_LAST is the
    // TIMEOUT-th such cycle. Cleared whenever ACCESS is not continuing.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wd_cnt <= '0;
        end else if (state == ACCESS && state_nxt == ACCESS) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_expired = (wd_cnt == WD_LAST);
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        done      = 1'b0;
        wd_fire   = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted so nothing is accepted then.
                cmd_ready = PRESETn;
                if (cmd_valid && PRESETn) state_nxt = SETUP;
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                // PREADY wins over a watchdog expiry in the same cycle.
                if (PREADY) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end else if (wd_expired) begin
                    wd_fire   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = cmd_valid & cmd_ready;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state    <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                paddr_q  <= cmd_addr;
                pwrite_q <= cmd_write;
                wdata_q  <= cmd_wdata;
            end
            if (done) begin
                rdata_q <= pwrite_q ? '0 : PRDATA;
                err_q   <= PSLVERR;
            end else if (wd_fire) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    // Write data only appears on the bus while a write is actually selected.
    assign PWDATA    = (PSEL && pwrite_q) ? wdata_q : '0;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master.sv
// Purpose : random and directed APB transfers against a memory-backed completer model.
// Latency : n/a (testbench).
// Backpr. : drives random wait states and response stalls.
module tb_apb_master;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO = 4;
    localparam bit WD = 1'b1;
`else
    localparam int TO = 255;
    localparam bit WD = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    // Completer memory: what a read at an address should return.
    logic [31:0] mem [logic [31:0]];

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic junk();
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
        PREADY  = 1'($urandom_range(0, 1));
    endtask

    // One complete command: accept, SETUP, ACCESS with `waits` low-PREADY cycles,
    // RESP held for `stall` cycles before rsp_ready.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic err, input int stall);
        logic [31:0] exp_pw, exp_rd, slv_rd;
        logic        exp_err;
        int          acc;
        int          t;
        exp_pw = wr ? wdata : 32'h0;
        slv_rd = wr ? 32'($urandom) : (mem.exists(addr) ? mem[addr] : 32'h0);
        if (WD && waits >= TO) begin
            acc     = TO;
            exp_err = 1'b1;
            exp_rd  = 32'h0;
        end else begin
            acc     = waits + 1;
            exp_err = err;
            exp_rd  = wr ? 32'h0 : slv_rd;
        end

        t = 0;
        while (!cmd_ready && t < 20) begin
            step();
            t++;
        end
        check_eq("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        rsp_ready = 1'($urandom_range(0, 1));
        junk();
        step();

        check_eq("setup_sel_en", {30'h0, PSEL, PENABLE}, 32'h2);
        check_eq("setup_paddr", PADDR, addr);
        check_eq("setup_pwrite", {31'h0, PWRITE}, {31'h0, wr});
        check_eq("setup_pwdata", PWDATA, exp_pw);
        check_eq("setup_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        // A different command presented now must be ignored.
        cmd_write = ~wr;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        junk();
        step();

        for (int i = 0; i < acc; i++) begin
            check_eq("access_sel_en", {30'h0, PSEL, PENABLE}, 32'h3);
            check_eq("access_paddr", PADDR, addr);
            check_eq("access_pwrite", {31'h0, PWRITE}, {31'h0, wr});
            check_eq("access_pwdata", PWDATA, exp_pw);
            check_eq("access_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            if (i == waits) begin
                PREADY  = 1'b1;
                PRDATA  = slv_rd;
                PSLVERR = err;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
            if (i == acc - 1) cmd_valid = 1'b0;
            rsp_ready = 1'($urandom_range(0, 1));
            step();
        end
        if (wr && !exp_err) mem[addr] = wdata;

        for (int s = 0; s <= stall; s++) begin
            check_eq("resp_valid", {31'h0, rsp_valid}, 32'h1);
            check_eq("resp_sel_en", {30'h0, PSEL, PENABLE}, 32'h0);
            check_eq("resp_rdata", rsp_rdata, exp_rd);
            check_eq("resp_err", {31'h0, rsp_err}, {31'h0, exp_err});
            check_eq("resp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            check_eq("resp_pwdata", PWDATA, 32'h0);
            check_eq("resp_paddr", PADDR, addr);
            rsp_ready = (s == stall);
            junk();
            step();
        end
        check_eq("after_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'hDEAD_BEEF;
        cmd_wdata = 32'h1234_5678;
        rsp_ready = 1'b0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        mem[32'h8] = 32'hA5;

        // Reset state
        repeat (3) step();
        check_eq("rst_sel_en", {30'h0, PSEL, PENABLE}, 32'h0);
        check_eq("rst_pwrite", {31'h0, PWRITE}, 32'h0);
        check_eq("rst_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
        check_eq("rst_paddr", PADDR, 32'h0);
        check_eq("rst_pwdata", PWDATA, 32'h0);
        check_eq("rst_rdata", rsp_rdata, 32'h0);
        check_eq("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        cmd_valid = 1'b0;
        PRESETn   = 1'b1;
        step();
        check_eq("rel_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        // Directed scenarios
        xfer(1'b1, 32'h4, 32'h41, 0, 1'b0, 0);
        xfer(1'b0, 32'h8, 32'h0, 3, 1'b0, 0);
        xfer(1'b0, 32'h8, 32'h0, 1, 1'b1, 5);

        // Reset while waiting in ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h10;
        PREADY    = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check_eq("abort_pre_en", {30'h0, PSEL, PENABLE}, 32'h3);
        PRESETn = 1'b0;
        step();
        check_eq("abort_sel_en", {30'h0, PSEL, PENABLE}, 32'h0);
        check_eq("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("abort_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check_eq("abort_paddr", PADDR, 32'h0);
        PREADY = 1'b1;
        step();
        check_eq("abort_rsp_valid2", {31'h0, rsp_valid}, 32'h0);
        PRESETn = 1'b1;
        step();
        check_eq("abort_rel_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check_eq("abort_rel_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        xfer(1'b0, 32'h4, 32'h0, 0, 1'b0, 0);

`ifdef APB_MASTER_TIMEOUT_EN
        xfer(1'b0, 32'h8, 32'h0, 50, 1'b0, 1);
        xfer(1'b0, 32'h8, 32'h0, TO - 1, 1'b0, 0);
        xfer(1'b1, 32'h8, 32'h77, TO, 1'b0, 0);
`endif

        // Random traffic
        for (int k = 0; k < 150; k++) begin
            xfer(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 2, $urandom,
                 $urandom_range(0, 6), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
